// File: rtl/mpram_pkg.sv
// mpram_pkg: shared definitions for the 4-port 16x8 RAM request front-end.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   NPORTS                  : number of RAM ports (a..d)
//   port_idx_t, PORT_A..D   : 2-bit port index type and named port indices
package mpram_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned NPORTS     = 4;

    typedef logic [1:0] port_idx_t;

    localparam port_idx_t PORT_A = 2'd0;
    localparam port_idx_t PORT_B = 2'd1;
    localparam port_idx_t PORT_C = 2'd2;
    localparam port_idx_t PORT_D = 2'd3;

endpackage

// File: rtl/mpram_rr_arbiter.sv
// mpram_rr_arbiter: same-cycle address-collision detection and rotating-priority
// grant for the four request channels (bit 0 = a ... bit 3 = d).
//   valid, we, addr : per-channel request fields
//   prio_ptr        : channel with highest priority this cycle
//   grant           : per-channel grant (combinational)
//   stall           : some valid request was not granted this cycle
module mpram_rr_arbiter
    import mpram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [NPORTS-1:0]             valid,
    input  logic [NPORTS-1:0]             we,
    input  logic [NPORTS-1:0][ADDR_W-1:0] addr,
    input  port_idx_t                     prio_ptr,
    output logic [NPORTS-1:0]             grant,
    output logic                          stall
);

    logic [NPORTS-1:0] match [NPORTS];
    port_idx_t         rank  [NPORTS];
    logic [NPORTS-1:0] blocked;

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            // distance from the priority pointer, wrapping a->b->c->d->a
            rank[k] = port_idx_t'(port_idx_t'(k) - prio_ptr);
        end
        for (int i = 0; i < NPORTS; i++) begin
            match[i]   = '0;
            blocked[i] = 1'b0;
            for (int j = 0; j < NPORTS; j++) begin
                match[i][j] = valid[i] && valid[j] && (addr[j] == addr[i]);
            end
            for (int j = 0; j < NPORTS; j++) begin
                if (j != i && match[i][j] && rank[j] < rank[i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        grant = '0;
        for (int i = 0; i < NPORTS; i++) begin
            // a group of pure reads never blocks; any write makes it exclusive
            grant[i] = valid[i] && !(blocked[i] && |(match[i] & we));
        end
        stall = |(valid & ~grant);
    end

endmodule

// File: rtl/mpram_port_arbiter.sv
// mpram_port_arbiter: request front-end for the 4-port RAM. Channel x always
// drives RAM port x; colliding requests involving a write are serialised.
//   clk, rst                 : clock, synchronous active-high reset
//   req_*_x                  : valid/ready request channel per port
//   rsp_valid_x, rsp_rdata_x : read response, two cycles after accept
//   ram_*_x                  : registered RAM port drive / RAM read data
//   conflict_cnt             : saturating count of cycles with a stall
module mpram_port_arbiter
    import mpram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_a,
    input  logic              req_valid_b,
    input  logic              req_valid_c,
    input  logic              req_valid_d,
    output logic              req_ready_a,
    output logic              req_ready_b,
    output logic              req_ready_c,
    output logic              req_ready_d,
    input  logic              req_we_a,
    input  logic              req_we_b,
    input  logic              req_we_c,
    input  logic              req_we_d,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [ADDR_W-1:0] req_addr_c,
    input  logic [ADDR_W-1:0] req_addr_d,
    input  logic [DATA_W-1:0] req_wdata_a,
    input  logic [DATA_W-1:0] req_wdata_b,
    input  logic [DATA_W-1:0] req_wdata_c,
    input  logic [DATA_W-1:0] req_wdata_d,
    output logic              rsp_valid_a,
    output logic              rsp_valid_b,
    output logic              rsp_valid_c,
    output logic              rsp_valid_d,
    output logic [DATA_W-1:0] rsp_rdata_a,
    output logic [DATA_W-1:0] rsp_rdata_b,
    output logic [DATA_W-1:0] rsp_rdata_c,
    output logic [DATA_W-1:0] rsp_rdata_d,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [ADDR_W-1:0] ram_addr_c,
    output logic [ADDR_W-1:0] ram_addr_d,
    output logic [DATA_W-1:0] ram_data_in_a,
    output logic [DATA_W-1:0] ram_data_in_b,
    output logic [DATA_W-1:0] ram_data_in_c,
    output logic [DATA_W-1:0] ram_data_in_d,
    output logic              ram_we_a,
    output logic              ram_we_b,
    output logic              ram_we_c,
    output logic              ram_we_d,
    input  logic [DATA_W-1:0] ram_data_out_a,
    input  logic [DATA_W-1:0] ram_data_out_b,
    input  logic [DATA_W-1:0] ram_data_out_c,
    input  logic [DATA_W-1:0] ram_data_out_d,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [NPORTS-1:0]             valid, we, grant, ready, accept;
    logic [NPORTS-1:0][ADDR_W-1:0] addr;
    logic [NPORTS-1:0][DATA_W-1:0] wdata;
    logic                          stall;

    logic [NPORTS-1:0][ADDR_W-1:0] ram_addr_q;
    logic [NPORTS-1:0][DATA_W-1:0] ram_data_q;
    logic [NPORTS-1:0]             ram_we_q;
    logic [NPORTS-1:0]             rsp_s1_q, rsp_s2_q;
    port_idx_t                     prio_ptr_q;
    logic [CNT_W-1:0]              conflict_cnt_q;

    assign valid = {req_valid_d, req_valid_c, req_valid_b, req_valid_a};
    assign we    = {req_we_d, req_we_c, req_we_b, req_we_a};
    assign addr  = {req_addr_d, req_addr_c, req_addr_b, req_addr_a};
    assign wdata = {req_wdata_d, req_wdata_c, req_wdata_b, req_wdata_a};

    mpram_rr_arbiter #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .valid    (valid),
        .we       (we),
        .addr     (addr),
        .prio_ptr (prio_ptr_q),
        .grant    (grant),
        .stall    (stall)
    );

    assign ready  = grant & {NPORTS{~rst}};
    assign accept = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_we_q       <= '0;
            rsp_s1_q       <= '0;
            rsp_s2_q       <= '0;
            prio_ptr_q     <= PORT_A;
            conflict_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (accept[k]) begin
                    ram_addr_q[k] <= addr[k];
                    ram_data_q[k] <= wdata[k];
                end
            end
            ram_we_q <= accept & we;
            rsp_s1_q <= accept & ~we;
            rsp_s2_q <= rsp_s1_q;
            if (stall) begin
                prio_ptr_q <= port_idx_t'(prio_ptr_q + port_idx_t'(1));
                if (conflict_cnt_q != '1) begin
                    conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign {req_ready_d, req_ready_c, req_ready_b, req_ready_a} = ready;
    assign {rsp_valid_d, rsp_valid_c, rsp_valid_b, rsp_valid_a} = rsp_s2_q;
    assign {ram_we_d, ram_we_c, ram_we_b, ram_we_a}             = ram_we_q;

    assign ram_addr_a    = ram_addr_q[0];
    assign ram_addr_b    = ram_addr_q[1];
    assign ram_addr_c    = ram_addr_q[2];
    assign ram_addr_d    = ram_addr_q[3];
    assign ram_data_in_a = ram_data_q[0];
    assign ram_data_in_b = ram_data_q[1];
    assign ram_data_in_c = ram_data_q[2];
    assign ram_data_in_d = ram_data_q[3];

    assign rsp_rdata_a = ram_data_out_a;
    assign rsp_rdata_b = ram_data_out_b;
    assign rsp_rdata_c = ram_data_out_c;
    assign rsp_rdata_d = ram_data_out_d;

    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mpram_port_arbiter.sv
// tb_mpram_port_arbiter: self-checking bench for mpram_port_arbiter with a
// behavioural 4-port RAM and a read-response scoreboard.
module tb_mpram_port_arbiter;

    localparam int CW = 3;  // narrow counter so saturation is reachable

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]      v, we;
    logic [3:0][3:0] ad;
    logic [3:0][7:0] wd;

    wire  [3:0]      rdy, rspv, rwe;
    wire  [3:0][7:0] rdat, rdin;
    wire  [3:0][3:0] radr;
    wire  [CW-1:0]   cnt;
    logic [7:0]      ram_q [4];

    mpram_port_arbiter #(
        .ADDR_W (4),
        .DATA_W (8),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_a    (v[0]),
        .req_valid_b    (v[1]),
        .req_valid_c    (v[2]),
        .req_valid_d    (v[3]),
        .req_ready_a    (rdy[0]),
        .req_ready_b    (rdy[1]),
        .req_ready_c    (rdy[2]),
        .req_ready_d    (rdy[3]),
        .req_we_a       (we[0]),
        .req_we_b       (we[1]),
        .req_we_c       (we[2]),
        .req_we_d       (we[3]),
        .req_addr_a     (ad[0]),
        .req_addr_b     (ad[1]),
        .req_addr_c     (ad[2]),
        .req_addr_d     (ad[3]),
        .req_wdata_a    (wd[0]),
        .req_wdata_b    (wd[1]),
        .req_wdata_c    (wd[2]),
        .req_wdata_d    (wd[3]),
        .rsp_valid_a    (rspv[0]),
        .rsp_valid_b    (rspv[1]),
        .rsp_valid_c    (rspv[2]),
        .rsp_valid_d    (rspv[3]),
        .rsp_rdata_a    (rdat[0]),
        .rsp_rdata_b    (rdat[1]),
        .rsp_rdata_c    (rdat[2]),
        .rsp_rdata_d    (rdat[3]),
        .ram_addr_a     (radr[0]),
        .ram_addr_b     (radr[1]),
        .ram_addr_c     (radr[2]),
        .ram_addr_d     (radr[3]),
        .ram_data_in_a  (rdin[0]),
        .ram_data_in_b  (rdin[1]),
        .ram_data_in_c  (rdin[2]),
        .ram_data_in_d  (rdin[3]),
        .ram_we_a       (rwe[0]),
        .ram_we_b       (rwe[1]),
        .ram_we_c       (rwe[2]),
        .ram_we_d       (rwe[3]),
        .ram_data_out_a (ram_q[0]),
        .ram_data_out_b (ram_q[1]),
        .ram_data_out_c (ram_q[2]),
        .ram_data_out_d (ram_q[3]),
        .conflict_cnt   (cnt)
    );

    // Behavioural RAM: registered read, old data on same-edge write.
    logic [7:0] mem   [16];
    logic [7:0] model [16];
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]   = 8'h00;
            model[i] = 8'h00;
        end
        for (int k = 0; k < 4; k++) ram_q[k] = 8'h00;
    end
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rwe[k]) mem[radr[k]] <= rdin[k];
            ram_q[k] <= mem[radr[k]];
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         due;
    } sb_t;
    sb_t sb[$];
    sb_t e;

    // Scoreboard: pop/compare responses, then record this cycle's accepts.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc_n) begin
            chk("rsp_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            if (rspv[k]) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_chan", k, e.ch);
                    chk("rsp_due", cyc_n, e.due);
                    chk("rsp_data", {24'd0, rdat[k]}, {24'd0, e.data});
                end
            end
        end
        if (rst) begin
            sb.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (v[k] && rdy[k]) begin
                    if (we[k]) model[ad[k]] = wd[k];
                    else sb.push_back('{k, model[ad[k]], cyc_n + 2});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v = 4'h0; we = 4'h0; ad = '0; wd = '0;
        v = 4'hF;
        repeat (3) step();
        chk("rst_ready", {28'd0, rdy}, 32'h0);
        chk("rst_we", {28'd0, rwe}, 32'h0);
        chk("rst_addr", {16'd0, radr}, 32'h0);
        chk("rst_data", rdin, 32'h0);
        chk("rst_rspv", {28'd0, rspv}, 32'h0);
        chk("rst_cnt", {29'd0, cnt}, 32'h0);
        chk("rst_prio", {30'd0, dut.prio_ptr_q}, 32'h0);
        v = 4'h0; rst = 1'b0;
        step();

        // No conflict: four writes to distinct addresses
        v = 4'hF; we = 4'hF;
        ad = {4'hF, 4'hA, 4'h7, 4'h3};
        wd = {8'h99, 8'h77, 8'h55, 8'hAA};
        #1 chk("nc_ready", {28'd0, rdy}, 32'hF);
        step();
        chk("nc_we", {28'd0, rwe}, 32'hF);
        chk("nc_addr", {16'd0, radr}, 32'h0000_FA73);
        chk("nc_data", rdin, 32'h9977_55AA);
        chk("nc_cnt", {29'd0, cnt}, 32'h0);

        // Read latency: a rd 3
        v = 4'h1; we = 4'h0; ad[0] = 4'h3;
        #1 chk("rl_ready", {28'd0, rdy}, 32'h1);
        step();
        v = 4'h0;
        chk("rl_t1_rspv", {28'd0, rspv}, 32'h0);
        step();
        chk("rl_t2_rspv", {28'd0, rspv}, 32'h1);
        chk("rl_t2_data", {24'd0, rdat[0]}, 32'hAA);
        step();
        chk("rl_t3_rspv", {28'd0, rspv}, 32'h0);

        // Write-write collision from prio a: a wr 5<-11, c wr 5<-22
        v = 4'h5; we = 4'h5; ad[0] = 4'h5; ad[2] = 4'h5; wd[0] = 8'h11; wd[2] = 8'h22;
        #1 chk("ww_ready0", {28'd0, rdy}, 32'h1);
        step();
        v = 4'h4;
        #1 chk("ww_ready1", {28'd0, rdy}, 32'h4);
        chk("ww_cnt", {29'd0, cnt}, 32'h1);
        chk("ww_prio", {30'd0, dut.prio_ptr_q}, 32'h1);
        step();
        v = 4'h2; we = 4'h0; ad[1] = 4'h5;
        step();
        v = 4'h0;
        step();
        chk("ww_rd_rspv", {28'd0, rspv}, 32'h2);
        chk("ww_rd_data", {24'd0, rdat[1]}, 32'h22);
        chk("ww_cnt_hold", {29'd0, cnt}, 32'h1);

        // Fairness: a..d all write address 2 from prio a
        rst = 1'b1;
        step();
        rst = 1'b0;
        v = 4'hF; we = 4'hF; ad = {4'h2, 4'h2, 4'h2, 4'h2};
        wd = {8'h04, 8'h03, 8'h02, 8'h01};
        #1 chk("fr_ready0", {28'd0, rdy}, 32'h1);
        step();
        v = 4'hE;
        #1 chk("fr_ready1", {28'd0, rdy}, 32'h2);
        step();
        v = 4'hC;
        #1 chk("fr_ready2", {28'd0, rdy}, 32'h4);
        step();
        v = 4'h8;
        #1 chk("fr_ready3", {28'd0, rdy}, 32'h8);
        step();
        v = 4'h1; we = 4'h0; ad[0] = 4'h2;
        step();
        v = 4'h0;
        step();
        chk("fr_rd_data", {24'd0, rdat[0]}, 32'h04);
        chk("fr_cnt", {29'd0, cnt}, 32'h3);

        // Read sharing: b rd 7 and d rd 7
        v = 4'hA; we = 4'h0; ad[1] = 4'h7; ad[3] = 4'h7;
        #1 chk("rs_ready", {28'd0, rdy}, 32'hA);
        step();
        v = 4'h0;
        step();
        chk("rs_rspv", {28'd0, rspv}, 32'hA);
        chk("rs_data_b", {24'd0, rdat[1]}, 32'h55);
        chk("rs_data_d", {24'd0, rdat[3]}, 32'h55);
        chk("rs_cnt", {29'd0, cnt}, 32'h3);

        // Saturation: a and b keep writing address 9, one stalls every cycle
        v = 4'h3; we = 4'h3; ad[0] = 4'h9; ad[1] = 4'h9; wd[0] = 8'h5A; wd[1] = 8'hA5;
        repeat (6) step();
        v = 4'h0;
        chk("sat_cnt", {29'd0, cnt}, 32'h7);
        v = 4'h4; we = 4'h0; ad[2] = 4'h9;
        step();
        v = 4'h0;
        repeat (3) step();

        // Reset mid-operation: read accepted, reset the next cycle
        v = 4'h1; we = 4'h0; ad[0] = 4'h3;
        #1 chk("mr_ready", {28'd0, rdy}, 32'h1);
        step();
        v = 4'h0; rst = 1'b1;
        #1 chk("mr_ready_rst", {28'd0, rdy}, 32'h0);
        step();
        chk("mr_rspv", {28'd0, rspv}, 32'h0);
        chk("mr_we", {28'd0, rwe}, 32'h0);
        chk("mr_addr", {16'd0, radr}, 32'h0);
        chk("mr_data", rdin, 32'h0);
        chk("mr_cnt", {29'd0, cnt}, 32'h0);
        chk("mr_prio", {30'd0, dut.prio_ptr_q}, 32'h0);
        rst = 1'b0;
        repeat (3) step();
        chk("sb_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpram_port_arbiter.md
# mpram_port_arbiter

Request front-end sitting directly upstream of the 4-port 16x8 RAM (ports a–d). It accepts one valid/ready request channel per RAM port and detects same-cycle address collisions involving a write. It serialises those collisions with a rotating priority and drives the RAM ports from registers. It also returns read data with a fixed-latency response valid, so requesters never see undefined collision behaviour.

## Interface
Parameters:
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- CNT_W, 16, width of the conflict statistics counter

Ports (x ∈ {a,b,c,d}, one bullet covers all four copies):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_x  in  1  request present on channel x
- req_ready_x  out  1  request accepted this cycle (combinational grant)
- req_we_x  in  1  1 = write, 0 = read
- req_addr_x  in  ADDR_W  request address
- req_wdata_x  in  DATA_W  write data
- rsp_valid_x  out  1  read data valid on rsp_rdata_x
- rsp_rdata_x  out  DATA_W  read data, driven from ram_data_out_x
- ram_addr_x  out  ADDR_W  to RAM port x address
- ram_data_in_x  out  DATA_W  to RAM port x write data
- ram_we_x  out  1  to RAM port x write enable
- ram_data_out_x  in  DATA_W  from RAM port x; registered read, valid one cycle after the address is sampled
- conflict_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Channel x always issues to RAM port x. There is no cross-port steering.
- Conflict group: two or more valid requests with equal address, at least one of them a write. Pure read sharing of one address is not a conflict. All such reads are granted.
- Within each conflict group, exactly one request is granted: the first requester at or after prio_ptr in the order a→b→c→d→a. All other members of the group get req_ready_x = 0.
- Non-conflicting valid requests are always granted.
- prio_ptr (2 bits) rotates by one on every cycle in which at least one valid request was stalled. Otherwise it holds. This guarantees a held request is granted within 4 cycles.
- Requester rule: while req_valid_x=1 and req_ready_x=0, the requester holds we, addr and wdata stable. The bench checks this, not the RTL.
- Issue on accept (valid & ready): ram_addr_x, ram_data_in_x and ram_we_x are registered from the request. If channel x is not accepted, ram_we_x is 0 next cycle and ram_addr_x/ram_data_in_x hold their values.
- Read response: an accepted read sets a 2-stage valid pipeline. rsp_valid_x = 1 exactly one cycle, two cycles after acceptance, with rsp_rdata_x = ram_data_out_x. Writes produce no response.
- conflict_cnt increments by 1 on each cycle with any stalled valid request. It saturates at all-ones and never wraps.

## Timing
- Accept in cycle T → RAM port driven in T+1 → read data and rsp_valid_x in T+2. Back-to-back accepts are allowed every cycle, giving full throughput per channel.
- Ordering: a write accepted in cycle T is visible to any read accepted in T+1 or later, on any channel.
- Within one cycle, a conflicting read and write to the same address take effect in grant order.
- Reset values: ram_we_x=0, ram_addr_x=0, ram_data_in_x=0, rsp_valid_x=0, conflict_cnt=0, prio_ptr=a.
- While rst=1: req_ready_x=0.
- Reset mid-operation: in-flight read valids are discarded. No rsp_valid_x is asserted for reads accepted before reset.

## Structure
- Shared package mpram_pkg: ADDR_W/DATA_W defaults, 2-bit port-index type, constants PORT_A..PORT_D.
- One sub-module: mpram_rr_arbiter. It performs pairwise address compare, conflict-group formation and rotating-priority grant for the 4 requesters. It outputs the grant vector and a stall flag.
- The top module contains the issue registers, the response valid pipelines, prio_ptr and conflict_cnt.

## Test plan
- No conflict: one cycle with a wr 3←AA, b wr 7←55, c wr A←77, d wr F←99 → all req_ready=1. Next cycle ram_we_a..d=1 with those addr/data. conflict_cnt=0.
- Read latency: a rd 3 accepted at T → rsp_valid_a=1 only at T+2, rsp_rdata_a=AA. No rsp_valid on write accepts.
- Write-write collision, prio_ptr=a: a wr 5←11 and c wr 5←22 → a granted, c stalled one cycle then granted. A later rd 5 returns 22. conflict_cnt=1, prio_ptr=b.
- Fairness: a–d all wr 2 (values 01..04) held from prio_ptr=a → grants in order a,b,c,d over 4 cycles. rd 2 returns 04. conflict_cnt=3.
- Read sharing: b rd 7 and d rd 7 in the same cycle → both granted. At T+2 both return 55. conflict_cnt unchanged.
- Reset mid-operation: rd accepted at T, rst=1 at T+1 → no rsp_valid at T+2. All outputs at reset values, prio_ptr=a.
